// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared motor codes, FSM states and gate selects for the gate sequencer
package parking_pkg;

  // Motor drive encoding; 2'b11 is never produced
  localparam logic [1:0] MOT_STOP  = 2'b00;
  localparam logic [1:0] MOT_OPEN  = 2'b01;
  localparam logic [1:0] MOT_CLOSE = 2'b10;

  // Sequencer phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    HOLD  = 2'd2,
    CLOSE = 2'd3
  } state_e;

  // Gate select values carried in sel_exit / last_grant
  localparam logic GATE_ENTRY = 1'b0;
  localparam logic GATE_EXIT  = 1'b1;

endpackage

// File: rtl/parking_gate_sequencer_if.sv
// rtl/parking_gate_sequencer_if.sv - sensor inputs and motor/status outputs of the gate sequencer
interface parking_gate_sequencer_if #(
  parameter int CNT_W = 3
);

  logic             entry_req;
  logic             entry_pass;
  logic             exit_pass;
  logic             exit_req;
  logic             pass_ok;
  logic [1:0]       entry_motor;
  logic [1:0]       exit_motor;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             busy;
  logic             sel_exit;

  // Environment side: drives sensors, observes motors and status
  modport master (
    output entry_req, entry_pass, exit_pass, exit_req, pass_ok,
    input  entry_motor, exit_motor, count, full, busy, sel_exit
  );

  // Sequencer side
  modport slave (
    input  entry_req, entry_pass, exit_pass, exit_req, pass_ok,
    output entry_motor, exit_motor, count, full, busy, sel_exit
  );

endinterface

// File: rtl/gate_timer.sv
// rtl/gate_timer.sv - loadable down-counter timing motor strokes and the hold window
module gate_timer #(
  parameter int TMR_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             done_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Load wins; otherwise count down and rest at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/parking_gate_sequencer.sv
// rtl/parking_gate_sequencer.sv - arbitrates entry/exit gates, sequences one motor at a time, tracks occupancy
module parking_gate_sequencer
  import parking_pkg::*;
#(
  parameter int MAX_CARS     = 7,
  parameter int CNT_W        = 3,
  parameter int MOVE_CYCLES  = 50,
  parameter int HOLD_TIMEOUT = 500,
  parameter int TMR_W        = 10
) (
  input logic                     clk,
  input logic                     rst_n,
  parking_gate_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CARS);
  localparam logic [TMR_W-1:0] MOVE_LD = TMR_W'(MOVE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic             passed_q, passed_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;

  logic             entry_elig;
  logic             exit_elig;
  logic             sens;
  logic [1:0]       drive;
  logic [1:0]       entry_mot;
  logic [1:0]       exit_mot;

  gate_timer #(
    .TMR_W(TMR_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  assign entry_elig = bus.entry_req & bus.pass_ok & ~full_q;
  assign exit_elig  = bus.exit_req & (count_q != '0);
  // Throat sensor of whichever gate currently owns the motor budget
  assign sens       = (sel_q == GATE_EXIT) ? bus.exit_pass : bus.entry_pass;

  // Next-state: arbitration in IDLE, then open/hold/close with obstruction reopen
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    passed_d = passed_q;
    count_d  = count_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (entry_elig || exit_elig) begin
          if (entry_elig && exit_elig) begin
            sel_d = ~last_q;
          end else begin
            sel_d = exit_elig ? GATE_EXIT : GATE_ENTRY;
          end
          state_d  = OPEN;
          tmr_load = 1'b1;
          tmr_val  = MOVE_LD;
        end
      end
      OPEN: begin
        if (tmr_done) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      HOLD: begin
        passed_d = passed_q | sens;
        if ((passed_q && !sens) || tmr_done) begin
          state_d  = CLOSE;
          tmr_load = 1'b1;
          tmr_val  = MOVE_LD;
          // The car is accounted for here, so a later reopen cannot count it twice
          passed_d = 1'b0;
          if (passed_q || sens) begin
            if (sel_q == GATE_EXIT) begin
              if (count_q != '0) count_d = count_q - 1'b1;
            end else begin
              if (count_q < MAX_CNT) count_d = count_q + 1'b1;
            end
          end
        end
      end
      CLOSE: begin
        if (sens) begin
          state_d  = OPEN;
          tmr_load = 1'b1;
          tmr_val  = MOVE_LD;
        end else if (tmr_done) begin
          state_d  = IDLE;
          last_d   = sel_q;
          passed_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full_d = (count_d == MAX_CNT);

  // State, grant and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= GATE_ENTRY;
      last_q   <= GATE_EXIT;
      passed_q <= 1'b0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      passed_q <= passed_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Motor decode from registered state; the non-granted gate always sees STOP
  always_comb begin
    entry_mot = MOT_STOP;
    exit_mot  = MOT_STOP;
    case (state_q)
      OPEN:    drive = MOT_OPEN;
      CLOSE:   drive = MOT_CLOSE;
      default: drive = MOT_STOP;
    endcase
    if (sel_q == GATE_EXIT) begin
      exit_mot = drive;
    end else begin
      entry_mot = drive;
    end
  end

  assign bus.entry_motor = entry_mot;
  assign bus.exit_motor  = exit_mot;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.sel_exit    = sel_q;

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// tb/tb_parking_gate_sequencer.sv - directed bench with behavioural model for the gate sequencer
module tb_parking_gate_sequencer;

  localparam int MAXC = 7;
  localparam int MOVE = 4;
  localparam int HOLDT = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  parking_gate_sequencer_if #(.CNT_W(3)) bus ();

  parking_gate_sequencer #(
    .MAX_CARS(MAXC), .CNT_W(3), .MOVE_CYCLES(MOVE), .HOLD_TIMEOUT(HOLDT), .TMR_W(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 opening, 2 holding, 3 closing; left = cycles remaining in phase
  int m_ph, m_left, m_cnt;
  bit m_sel, m_last, m_seen;

  always @(posedge clk or negedge rst_n) begin : model
    int ph, left, cnt;
    bit sel, last, seen, sens, hit, e, x;
    if (!rst_n) begin
      m_ph <= 0; m_left <= 0; m_cnt <= 0; m_sel <= 0; m_last <= 1; m_seen <= 0;
    end else begin
      ph = m_ph; left = m_left; cnt = m_cnt; sel = m_sel; last = m_last; seen = m_seen;
      sens = sel ? bus.exit_pass : bus.entry_pass;
      case (ph)
        0: begin
          e = bus.entry_req && bus.pass_ok && (cnt < MAXC);
          x = bus.exit_req && (cnt > 0);
          if (e || x) begin
            sel = (e && x) ? !last : x;
            ph = 1; left = MOVE;
          end
        end
        1: begin
          left--;
          if (left == 0) begin ph = 2; left = HOLDT; end
        end
        2: begin
          hit = seen || sens;
          left--;
          if ((seen && !sens) || left == 0) begin
            if (hit) cnt = sel ? ((cnt > 0) ? cnt - 1 : 0) : ((cnt < MAXC) ? cnt + 1 : cnt);
            ph = 3; left = MOVE; seen = 0;
          end else begin
            seen = hit;
          end
        end
        default: begin
          if (sens) begin
            ph = 1; left = MOVE;
          end else begin
            left--;
            if (left == 0) begin ph = 0; last = sel; end
          end
        end
      endcase
      m_ph <= ph; m_left <= left; m_cnt <= cnt; m_sel <= sel; m_last <= last; m_seen <= seen;
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("entry_motor", bus.entry_motor, (m_ph == 1 && !m_sel) ? 1 : (m_ph == 3 && !m_sel) ? 2 : 0);
      chk("exit_motor", bus.exit_motor, (m_ph == 1 && m_sel) ? 1 : (m_ph == 3 && m_sel) ? 2 : 0);
      chk("count", bus.count, m_cnt);
      chk("full", bus.full, (m_cnt == MAXC) ? 1 : 0);
      chk("busy", bus.busy, (m_ph != 0) ? 1 : 0);
      if (m_ph != 0) chk("sel_exit", bus.sel_exit, m_sel);
    end
  end

  // Cumulative activity counters taken from the DUT pins
  int mon_eo = 0, mon_ec = 0, mon_xnz = 0, mon_busy = 0, mon_hold = 0, mon_both = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.entry_motor == 2'b01) mon_eo++;
      if (bus.entry_motor == 2'b10) mon_ec++;
      if (bus.exit_motor != 2'b00) mon_xnz++;
      if (bus.busy) mon_busy++;
      if (bus.busy && bus.entry_motor == 2'b00 && bus.exit_motor == 2'b00) mon_hold++;
      if (bus.entry_motor != 2'b00 && bus.exit_motor != 2'b00) mon_both++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ph(input int p, input string nm);
    int k = 0;
    while (m_ph != p && k < 300) begin
      tick(1);
      k++;
    end
    if (m_ph != p) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout %s: phase %0d never reached", nm, p);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.entry_req = 0; bus.entry_pass = 0; bus.exit_pass = 0; bus.exit_req = 0; bus.pass_ok = 0;
    tick(2);
    chk("rst entry_motor", bus.entry_motor, 0);
    chk("rst exit_motor", bus.exit_motor, 0);
    chk("rst count", bus.count, 0);
    chk("rst busy", bus.busy, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic do_entry(input int pass_len);
    bus.entry_req = 1; bus.pass_ok = 1;
    tick(1);
    bus.entry_req = 0; bus.pass_ok = 0;
    wait_ph(2, "entry hold");
    if (pass_len > 0) begin
      bus.entry_pass = 1;
      tick(pass_len);
      bus.entry_pass = 0;
    end
    wait_ph(0, "entry idle");
  endtask

  task automatic do_exit(input int pass_len);
    bus.exit_req = 1;
    tick(1);
    bus.exit_req = 0;
    wait_ph(2, "exit hold");
    bus.exit_pass = 1;
    tick(pass_len);
    bus.exit_pass = 0;
    wait_ph(0, "exit idle");
  endtask

  // One sequence with requests left as they are: check the granted gate and resulting count
  task automatic serve(input int exp_sel, input int exp_cnt, input string nm);
    wait_ph(2, nm);
    chk({nm, " sel"}, bus.sel_exit, exp_sel);
    if (m_sel) bus.exit_pass = 1; else bus.entry_pass = 1;
    tick(2);
    bus.exit_pass = 0; bus.entry_pass = 0;
    wait_ph(0, nm);
    chk({nm, " count"}, bus.count, exp_cnt);
  endtask

  initial begin
    int s_eo, s_ec, s_x, s_b, s_h;
    bus.entry_req = 0; bus.entry_pass = 0; bus.exit_pass = 0; bus.exit_req = 0; bus.pass_ok = 0;

    // 1: single entry with a 3-cycle pass
    do_reset();
    s_eo = mon_eo; s_ec = mon_ec; s_x = mon_xnz; s_h = mon_hold;
    do_entry(3);
    chk("t1 open cycles", mon_eo - s_eo, 4);
    chk("t1 close cycles", mon_ec - s_ec, 4);
    chk("t1 hold cycles", mon_hold - s_h, 4);
    chk("t1 exit motor idle", mon_xnz - s_x, 0);
    chk("t1 count", bus.count, 1);

    // 2: exit request with an empty lot
    do_reset();
    s_b = mon_busy;
    bus.exit_req = 1;
    tick(50);
    bus.exit_req = 0;
    chk("t2 busy cycles", mon_busy - s_b, 0);

    // 3: round-robin with all requests held at count 3 and last grant = exit
    do_reset();
    repeat (4) do_entry(2);
    do_exit(2);
    chk("t3 start count", bus.count, 3);
    bus.entry_req = 1; bus.exit_req = 1; bus.pass_ok = 1;
    serve(0, 4, "t3 first");
    serve(1, 3, "t3 second");
    serve(0, 4, "t3 third");
    bus.entry_req = 0; bus.exit_req = 0; bus.pass_ok = 0;
    tick(3);
    chk("t3 no overlap", mon_both, 0);

    // 4: full lot blocks entry until an exit completes
    do_reset();
    repeat (7) do_entry(1);
    chk("t4 count", bus.count, 7);
    chk("t4 full", bus.full, 1);
    s_b = mon_busy;
    bus.entry_req = 1; bus.pass_ok = 1;
    tick(10);
    chk("t4 blocked", mon_busy - s_b, 0);
    bus.exit_req = 1;
    tick(1);
    bus.exit_req = 0;
    serve(1, 6, "t4 exit");
    chk("t4 not full", bus.full, 0);
    serve(0, 7, "t4 entry");
    bus.entry_req = 0; bus.pass_ok = 0;
    tick(2);

    // 5: no car passes, hold times out
    do_reset();
    s_h = mon_hold; s_ec = mon_ec;
    do_entry(0);
    chk("t5 hold cycles", mon_hold - s_h, 20);
    chk("t5 close cycles", mon_ec - s_ec, 4);
    chk("t5 count", bus.count, 0);

    // 6: obstruction during close, then reset mid-open
    do_reset();
    bus.entry_req = 1; bus.pass_ok = 1;
    tick(1);
    bus.entry_req = 0; bus.pass_ok = 0;
    wait_ph(2, "t6 hold");
    bus.entry_pass = 1;
    tick(1);
    bus.entry_pass = 0;
    wait_ph(3, "t6 close");
    tick(1);
    bus.entry_pass = 1;
    s_eo = mon_eo;
    tick(1);
    bus.entry_pass = 0;
    @(negedge clk);
    chk("t6 reopen", bus.entry_motor, 1);
    chk("t6 count", bus.count, 1);
    wait_ph(2, "t6 rehold");
    chk("t6 reopen cycles", mon_eo - s_eo, 4);
    wait_ph(0, "t6 idle");
    chk("t6 count kept", bus.count, 1);
    bus.entry_req = 1; bus.pass_ok = 1;
    tick(1);
    bus.entry_req = 0; bus.pass_ok = 0;
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 async entry_motor", bus.entry_motor, 0);
    chk("t6 async busy", bus.busy, 0);
    chk("t6 async count", bus.count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/parking_gate_sequencer.md
Name: parking_gate_sequencer

Overview:
Sequences the entry and exit gate motors of the parking controller so that only one gate moves at a time, because both share one motor power budget. It arbitrates between entry and exit requests and runs each gate through open, hold and close phases. It maintains the occupancy count and the full flag. It sits between the sensor conditioning and password FSM outputs and the two 2-bit motor drive buses.

Parameters:
MAX_CARS, 7, capacity; full asserts when count equals this value
CNT_W, 3, occupancy counter width; must satisfy 2**CNT_W > MAX_CARS
MOVE_CYCLES, 50, clock cycles the motor is driven for one open or one close stroke (≥1)
HOLD_TIMEOUT, 500, maximum cycles the gate stays open waiting for the car to pass (≥1)
TMR_W, 10, timer width; must hold max(MOVE_CYCLES, HOLD_TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
entry_req  in  1  car waiting at entry (conditioned sensor 1)
entry_pass  in  1  car in entry gate throat (conditioned sensor 2)
exit_pass  in  1  car in exit gate throat (conditioned sensor 3)
exit_req  in  1  car waiting at exit (conditioned sensor 4)
pass_ok  in  1  password accepted; level signal from the password FSM
entry_motor  out  2  entry gate drive: 00 stop, 01 open, 10 close
exit_motor  out  2  exit gate drive, same encoding
count  out  CNT_W  current occupancy
full  out  1  count == MAX_CARS
busy  out  1  state != IDLE
sel_exit  out  1  gate currently granted: 0 entry, 1 exit; valid while busy

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, both motors 00, count 0, full 0, busy 0, sel_exit 0, last_grant = exit (so entry wins the first tie), passed flag 0, timer 0.
- Drive code 11 is never emitted.
- The non-granted motor is always 00, so both motors are never non-zero in the same cycle.
- All outputs are registered or decoded directly from registers. There is no combinational path from input to output.
- Eligibility, evaluated only in IDLE:
  - Entry is eligible when entry_req & pass_ok & !full.
  - Exit is eligible when exit_req & (count != 0).
- Arbitration:
  - One eligible side is granted.
  - Both eligible: grant the side opposite last_grant (round-robin).
  - The grant registers sel_exit and moves to OPEN on the next edge, loading timer = MOVE_CYCLES-1.
- OPEN:
  - Selected motor = 01. The timer decrements each cycle.
  - At timer==0, go to HOLD with timer = HOLD_TIMEOUT-1. Exactly MOVE_CYCLES cycles of 01 are driven.
- HOLD:
  - Selected motor = 00.
  - passed is set when the selected pass sensor is high.
  - Go to CLOSE (timer = MOVE_CYCLES-1) when passed & pass sensor low, or when the timer expires (timer==0).
  - On leaving HOLD with passed=1, update the count on the same edge. Entry: count+1, saturating at MAX_CARS. Exit: count-1, saturating at 0.
  - Timeout with passed=0 leaves count unchanged.
  - Timeout while the sensor is still high goes to CLOSE anyway. Obstruction handling below covers this case.
- CLOSE:
  - Selected motor = 10 for MOVE_CYCLES cycles, then go to IDLE.
  - On going to IDLE, set last_grant = sel_exit and clear passed.
- Obstruction: if the selected pass sensor is high during CLOSE, go to OPEN next edge with the timer reloaded. The count is not touched; the count only changes at the HOLD exit.
- full and count change only at the HOLD exit.
- Requests arriving while busy are ignored and re-evaluated in IDLE; no request queuing.
- pass_ok dropping after the grant does not abort the sequence.
- Reset asserted mid-operation: motors go to 00 immediately (asynchronously) and all state returns to reset values, including count=0.
- Minimum sequence length: 1 grant cycle + MOVE_CYCLES + ≥1 HOLD cycle + MOVE_CYCLES.

Decomposition:
- Shared package parking_pkg holds:
  - motor codes MOT_STOP=2'b00, MOT_OPEN=2'b01, MOT_CLOSE=2'b10;
  - state encoding IDLE/OPEN/HOLD/CLOSE as a 2-bit typedef;
  - the GATE_ENTRY/GATE_EXIT select constants.
- One sub-module is natural: gate_timer, a loadable TMR_W down-counter with load, load value and done (count==0) outputs, instantiated once.
- The occupancy counter and arbiter stay in the top.

Test Plan (MOVE_CYCLES=4, HOLD_TIMEOUT=20, MAX_CARS=7):
1. Reset, then entry_req=1 and pass_ok=1; pulse entry_pass in HOLD for 3 cycles -> entry_motor shows 01 for 4 cycles, then 00, then 10 for 4 cycles; count goes 0→1; exit_motor stays 00 throughout.
2. Exit with count=0: exit_req=1 held for 50 cycles -> no grant, busy=0, both motors 00.
3. entry_req, exit_req and pass_ok all asserted at count=3 from reset, held high -> entry is served first (count 3→4), then exit (count 4→3), then entry again. Both motors are never non-zero together.
4. Preload count to 7: entry_req=1, pass_ok=1 -> full=1 and no entry grant; a concurrent exit completes, giving count=6 and full=0; the entry is then granted.
5. Entry granted but entry_pass never asserts -> HOLD lasts exactly 20 cycles, then 4 cycles of 10; count unchanged.
6. entry_pass goes high in the 2nd CLOSE cycle -> the next cycle drives 01 for 4 cycles. Then assert rst_n=0 mid-OPEN -> motors 00 asynchronously, count=0, busy=0.
